reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the reset-deassert synchronizer chain (legal: >=2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, number of cycles all domain resets stay held after the synchronized release (legal: >=1).
REQ-003 SHALL have parameter N_DOM, default 4, number of reset domains driven (legal: >=1).
REQ-004 SHALL have parameter STAGGER, default 8, cycles between consecutive domain releases (legal: >=1).
REQ-005 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port sw_rst_req, input, 1, software reset request, sampled on clk rising edge.
REQ-008 SHALL have port sw_rst_ack, output, 1, one-cycle acknowledge of an accepted sw_rst_req.
REQ-009 SHALL have port dom_rst, output, N_DOM, active-high per-domain resets with asynchronous assert and synchronous, staggered release.
REQ-010 SHALL have port rst_done, output, 1, high only when every dom_rst bit is released.

Function
REQ-011 SHALL pass rst through an SYNC_STAGES-deep chain, set to 1 asynchronously by rst and shifting in 0 each edge; rst_s is the last chain flop.
REQ-012 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN.
REQ-013 SHALL stay in ASSERT while rst_s=1 and move to HOLD, counter cleared, on the first edge that samples rst_s=0.
REQ-014 SHALL in HOLD increment the hold counter each edge and on the edge where it equals HOLD_CYCLES-1 enter RELEASE and clear dom_rst[0].
REQ-015 SHALL in RELEASE clear dom_rst[i] exactly STAGGER edges after dom_rst[i-1] cleared, releasing in ascending index order only.
REQ-016 SHALL on the edge clearing dom_rst[N_DOM-1] enter RUN and set rst_done=1; with N_DOM=1 this is the edge clearing dom_rst[0].
REQ-017 SHALL in RUN on an edge sampling sw_rst_req=1 set all dom_rst bits, clear rst_done, pulse sw_rst_ack for exactly one cycle, and enter HOLD with counter cleared.
REQ-018 SHALL ignore sw_rst_req in ASSERT, HOLD and RELEASE (no ack, no restart); a request held high across RUN re-entry is accepted on the first RUN edge.
REQ-019 SHALL size the counters $clog2-wide from HOLD_CYCLES and STAGGER with no wrap-around inside a sequence.
REQ-020 SHALL never drive any dom_rst bit from combinational logic; every output is a flop.

Reset
REQ-021 SHALL on rst=1, asynchronously and at any point including mid-RELEASE or mid-sw sequence, set dom_rst to all ones, rst_done=0, sw_rst_ack=0, counters=0, chain to all ones and state ASSERT.
REQ-022 SHALL restart the full sequence from REQ-013 after rst deasserts, with no state carried over.

Configuration
REQ-023 SHALL compile the software-reset path only when macro RESET_SEQUENCER_SW_REQ_EN is defined.
REQ-024 SHALL without RESET_SEQUENCER_SW_REQ_EN keep port sw_rst_req (ignored), tie sw_rst_ack to 0 and never leave RUN except via rst.

Structure
REQ-025 SHALL take the FSM state typedef and the default parameter constants from shared package rst_seq_pkg.
REQ-026 SHALL instantiate sub-module rst_sync (async-assert/sync-deassert chain, parameter SYNC_STAGES) for REQ-011.

Verification
REQ-027 SHALL cover the defaults with rst released between edges 0 and 1: dom_rst[0] clears at edge 19, dom_rst[1] at 27, dom_rst[2] at 35, dom_rst[3] and rst_done=1 at 43.
REQ-028 SHALL cover rst pulsed at edge 30 mid-RELEASE: dom_rst returns to 4'b1111 and rst_done=0 immediately without a clock edge, then the full REQ-027 timing repeats relative to the new release.
REQ-029 SHALL cover a one-cycle sw_rst_req in RUN with the macro defined: sw_rst_ack high for exactly one cycle, dom_rst=4'b1111 at that edge, dom_rst[0] clears 16 edges later and rst_done returns 40 edges after acceptance.
REQ-030 SHALL cover sw_rst_req held high during HOLD: no ack until RUN, then exactly one ack per RUN entry.
REQ-031 SHALL cover the build without the macro: sw_rst_req toggling in RUN leaves dom_rst=0, rst_done=1 and sw_rst_ack=0.
REQ-032 SHALL cover N_DOM=1, HOLD_CYCLES=1, SYNC_STAGES=3: dom_rst[0] clears and rst_done sets on the same edge, 5 edges after the rst fall.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer and its synchronizer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_seq_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int HOLD_CYCLES_DEF = 16;
  localparam int N_DOM_DEF       = 4;
  localparam int STAGGER_DEF     = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer: every flop is forced to 1 by rst
// and the chain shifts in 0 on each clk edge once rst is low.
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: synchronized release, hold, then staggered
// per-domain release. Software reset path exists only with RESET_SEQUENCER_SW_REQ_EN.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int N_DOM       = N_DOM_DEF,
  parameter int STAGGER     = STAGGER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic [N_DOM-1:0] dom_rst,
  output logic             rst_done
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int SW = cnt_width(STAGGER);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);

  rst_seq_state_e   state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]    stag_cnt_q, stag_cnt_d;
  logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
  logic             rst_done_q, rst_done_d;
  logic             sw_rst_ack_q, sw_rst_ack_d;
  logic             rst_s;
  logic             sw_take;
  logic [N_DOM-1:0] dom_shift;
  logic             release_last;
  logic             hold_end;
  logic             stag_end;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk  (clk),
    .rst  (rst),
    .rst_s(rst_s)
  );

`ifdef RESET_SEQUENCER_SW_REQ_EN
  assign sw_take = sw_rst_req;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req;
  assign sw_take = 1'b0;
`endif

  // Released domains are the low-order zeros, so the next release is a left shift.
  assign dom_shift    = dom_rst_q << 1;
  assign release_last = (dom_shift == '0);
  assign hold_end     = (hold_cnt_q == HOLD_LAST);
  assign stag_end     = (stag_cnt_q == STAG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ASSERT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ASSERT: begin
        if (!rst_s) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_end) state_d = release_last ? ST_RUN : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (stag_end && release_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sw_take) state_d = ST_HOLD;
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    stag_cnt_d   = stag_cnt_q;
    dom_rst_d    = dom_rst_q;
    rst_done_d   = rst_done_q;
    sw_rst_ack_d = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        hold_cnt_d = '0;
        stag_cnt_d = '0;
        dom_rst_d  = '1;
        rst_done_d = 1'b0;
      end
      ST_HOLD: begin
        if (hold_end) begin
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          dom_rst_d  = dom_shift;
          rst_done_d = release_last;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stag_end) begin
          stag_cnt_d = '0;
          dom_rst_d  = dom_shift;
          rst_done_d = release_last;
        end else begin
          stag_cnt_d = stag_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (sw_take) begin
          hold_cnt_d   = '0;
          stag_cnt_d   = '0;
          dom_rst_d    = '1;
          rst_done_d   = 1'b0;
          sw_rst_ack_d = 1'b1;
        end
      end
      default: begin
        dom_rst_d  = '1;
        rst_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      stag_cnt_q   <= '0;
      dom_rst_q    <= '1;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      dom_rst_q    <= dom_rst_d;
      rst_done_q   <= rst_done_d;
      sw_rst_ack_q <= sw_rst_ack_d;
    end
  end

  assign dom_rst    = dom_rst_q;
  assign rst_done   = rst_done_q;
  assign sw_rst_ack = sw_rst_ack_q;

endmodule
